rvsteel_uart_fifo: RTL and testbench
====================================

// Module: rvsteel_uart_fifo
// PURPOSE
//  Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, optional parity and error flags.
//  Sits on the RISC-V Steel IO bus beside the other peripherals.
//  Drives the system UART pins.
//  Raises a level interrupt to the CPU while RX data or errors are pending.
// PARAMETERS
//  CLOCK_FREQUENCY  50000000  system clock in Hz
//  UART_BAUD_RATE   9600      reset baud; reset divisor = CLOCK_FREQUENCY/UART_BAUD_RATE
//  FIFO_DEPTH       8         entries per FIFO; power of 2, >= 2
// PORTS
//  clock           in   1   single system clock, rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  rw_address      in   5   byte address of register
//  read_data       out  32  registered read data
//  read_request    in   1   read strobe
//  read_response   out  1   read acknowledge
//  write_data      in   32  write data, full-word writes
//  write_request   in   1   write strobe
//  write_response  out  1   write acknowledge
//  uart_rx         in   1   serial input, asynchronous
//  uart_tx         out  1   serial output, idle high
//  uart_irq        out  1   level interrupt
// BEHAVIOUR
//  Reset (async): uart_tx=1, read_data=0, responses=0, uart_irq=0, FIFOs empty, sticky flags 0.
//    Reset also sets CTRL=0x4 and DIVISOR=reset value.
//    Assertion mid-frame aborts the frame immediately; no partial byte enters the RX FIFO.
//  Bus: read_response/write_response = request delayed 1 cycle.
//    read_data is valid with read_response and is 0 in every cycle without a read.
//  Registers: 0x00 WDATA, 0x04 RDATA, 0x08 STATUS, 0x0C CTRL, 0x10 DIVISOR.
//    Reads of any other address return 0; writes to them are ignored.
//  0x00 WDATA (W): push write_data[7:0] to the TX FIFO.
//    If the TX FIFO is full, the data is dropped and tx_ovf is set.
//  0x04 RDATA (R): returns {24'b0, head}, then pops.
//    If the RX FIFO is empty, returns 0 and does not pop.
//  0x08 STATUS (R):
//    b0 tx_idle (TX FIFO empty and shifter idle), b1 tx_full, b2 rx_avail, b3 rx_full.
//    Sticky bits: b4 rx_ovr, b5 frame_err, b6 parity_err, b7 tx_ovf.
//  0x08 STATUS (W): write-1-to-clear of b4..b7. A same-cycle set wins over clear.
//  0x0C CTRL (RW): b0 par_en, b1 par_odd, b2 rx_irq_en, b3 err_irq_en.
//  0x10 DIVISOR (RW): 16 bits, clock cycles per bit. Writes below 4 store 4.
//    CTRL and DIVISOR are latched per frame: a change takes effect at the next start bit.
//  TX: when the TX FIFO is non-empty and the shifter is idle, pop and send the frame.
//    Frame: start(0), d0..d7 LSB first, [parity], stop(1). Each bit lasts exactly DIVISOR cycles.
//    Back-to-back frames have no idle gap. uart_tx is driven from a flop (glitch-free).
//  RX: uart_rx passes a 2-flop synchroniser.
//    IDLE: a 1->0 transition goes to START.
//    START: sample at DIVISOR/2. If the sample is 1 (false start), return to IDLE.
//    DATA: 8 samples at DIVISOR spacing. PARITY: 1 sample when par_en. STOP: 1 sample.
//    If stop=0: set frame_err, discard byte. If parity mismatches: set parity_err, discard byte.
//    After a frame_err, wait for the line to be high before returning to IDLE.
//    Otherwise push the byte. If the RX FIFO is full, the byte is dropped and rx_ovr is set.
//    Pop and push in the same cycle when full: both succeed, count unchanged.
//  Parity: even = ^data; odd = ~^data.
//  IRQ: uart_irq = (rx_irq_en & rx_avail) | (err_irq_en & (rx_ovr|frame_err|parity_err|tx_ovf)).
//    Registered; it clears only by draining the RX FIFO or clearing the flags.
//  FIFO count is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//  Shared header rvsteel_uart_defs.vh:
//    register offsets, STATUS/CTRL bit indices, RX state encodings (IDLE/START/DATA/PARITY/STOP).
//  Sub-module rvsteel_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, instanced twice.
//  TX shifter, RX sampler and register file stay in this module.
// TESTING
//  Test params: CLOCK_FREQUENCY=1000000, UART_BAUD_RATE=100000 (divisor 10).
//  1. Write 0x55 to WDATA -> uart_tx shows 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles.
//     STATUS.b0 returns to 1 after the frame.
//  2. Send 0xA3 on uart_rx with rx_irq_en=1 -> uart_irq rises after the stop sample.
//     RDATA returns 0x000000A3; uart_irq falls; a second RDATA returns 0.
//  3. Push 9 bytes with TX busy, FIFO_DEPTH=8 -> 9th dropped, STATUS.b7=1.
//     Write 0x80 to STATUS -> b7=0.
//  4. Receive 9 frames without reading -> first 8 read back in order, STATUS.b4=1.
//     Same-cycle pop+push when full is accepted.
//  5. CTRL=0x3 (odd parity), rx frame with wrong parity bit -> parity_err=1, FIFO empty.
//     Stop bit 0 -> frame_err=1, FIFO empty.
//  6. 3-cycle low glitch on uart_rx -> no byte, no flag.
//     reset_n low mid-TX -> uart_tx=1 immediately; all STATUS bits 0 except b0 after release.

Source files
------------

// File: rtl/rvsteel_uart_fifo_pkg.sv
// Shared definitions for the FIFO-backed UART: register map, STATUS/CTRL bit
// positions, RX sampler state encodings and the parity helper.
package rvsteel_uart_fifo_pkg;

  localparam logic [4:0] ADDR_WDATA   = 5'h00;
  localparam logic [4:0] ADDR_RDATA   = 5'h04;
  localparam logic [4:0] ADDR_STATUS  = 5'h08;
  localparam logic [4:0] ADDR_CTRL    = 5'h0C;
  localparam logic [4:0] ADDR_DIVISOR = 5'h10;

  localparam int ST_TX_IDLE    = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVR     = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_PARITY_ERR = 6;
  localparam int ST_TX_OVF     = 7;

  localparam int CTRL_PAR_EN      = 0;
  localparam int CTRL_PAR_ODD     = 1;
  localparam int CTRL_RX_IRQ_EN   = 2;
  localparam int CTRL_ERR_IRQ_EN  = 3;

  localparam logic [3:0]  CTRL_RESET = 4'h4;
  localparam logic [15:0] DIV_MIN    = 16'd4;

  // WAIT_HIGH parks the sampler after a framing error until the line idles.
  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/rvsteel_uart_fifo_sync.sv
// Single-clock FIFO with count; a pop and a push in the same cycle both
// succeed even when full, leaving the count unchanged.
module rvsteel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rvsteel_uart_fifo.sv
// Memory-mapped UART for the RISC-V Steel IO bus: TX/RX FIFOs, runtime
// divisor, optional parity, sticky error flags and a level interrupt.
module rvsteel_uart_fifo
  import rvsteel_uart_fifo_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic        write_request,
  output logic        write_response,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_irq
);

  localparam logic [15:0] RESET_DIV = 16'(CLOCK_FREQUENCY / UART_BAUD_RATE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus-facing registers
  logic [31:0] read_data_q, read_data_d;
  logic        read_resp_q, write_resp_q;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  flags_q, flags_d;     // {tx_ovf, parity_err, frame_err, rx_ovr}
  logic        irq_q, irq_d;

  logic wr_wdata, wr_status, wr_ctrl, wr_div, rd_rdata;
  logic [3:0] flag_clr, flag_set;

  // FIFO interfaces
  logic [7:0]    tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_load, rx_push;

  // TX shifter
  logic        tx_busy_q, tx_busy_d;
  logic        tx_line_q, tx_line_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_bits_q, tx_bits_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;

  // RX sampler
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [2:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic        rx_par_en_q, rx_par_en_d;
  logic        rx_par_odd_q, rx_par_odd_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_par_q, rx_par_d;
  logic        frame_err_set, parity_err_set;

  logic [7:0]  status;
  logic        unused_bits;

  assign unused_bits = ^{write_data[31:16], tx_count, rx_count};

  assign wr_wdata  = write_request & (rw_address == ADDR_WDATA);
  assign wr_status = write_request & (rw_address == ADDR_STATUS);
  assign wr_ctrl   = write_request & (rw_address == ADDR_CTRL);
  assign wr_div    = write_request & (rw_address == ADDR_DIVISOR);
  assign rd_rdata  = read_request  & (rw_address == ADDR_RDATA);

  rvsteel_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (wr_wdata),
    .push_data_i (write_data[7:0]),
    .pop_i       (tx_load),
    .head_o      (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

  rvsteel_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (rx_push),
    .push_data_i (rx_shift_q),
    .pop_i       (rd_rdata),
    .head_o      (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count)
  );

  assign status = {flags_q, rx_full, ~rx_empty, tx_full, tx_empty & ~tx_busy_q};

  // A pop in the same cycle frees a slot, so neither overflow flag fires then.
  assign flag_set = {wr_wdata & tx_full & ~tx_load, parity_err_set, frame_err_set,
                     rx_push & rx_full & ~rd_rdata};
  assign flag_clr = wr_status ? write_data[7:4] : 4'b0000;

  always_comb begin
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    if (wr_ctrl) ctrl_d = write_data[3:0];
    if (wr_div)  div_d  = (write_data[15:0] < DIV_MIN) ? DIV_MIN : write_data[15:0];
    flags_d = (flags_q & ~flag_clr) | flag_set;
    irq_d   = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CTRL_ERR_IRQ_EN] & (|flags_q));

    read_data_d = 32'h0;
    if (read_request) begin
      case (rw_address)
        ADDR_RDATA:   read_data_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        ADDR_STATUS:  read_data_d = {24'h0, status};
        ADDR_CTRL:    read_data_d = {28'h0, ctrl_q};
        ADDR_DIVISOR: read_data_d = {16'h0, div_q};
        default:      read_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= 32'h0;
      read_resp_q  <= 1'b0;
      write_resp_q <= 1'b0;
      ctrl_q       <= CTRL_RESET;
      div_q        <= RESET_DIV;
      flags_q      <= 4'b0000;
      irq_q        <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_resp_q  <= read_request;
      write_resp_q <= write_request;
      ctrl_q       <= ctrl_d;
      div_q        <= div_d;
      flags_q      <= flags_d;
      irq_q        <= irq_d;
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_resp_q;
  assign write_response = write_resp_q;
  assign uart_irq       = irq_q;
  assign uart_tx        = tx_line_q;

  // Loading on the last stop-bit cycle chains frames with no idle gap.
  assign tx_load = ~tx_empty & (~tx_busy_q | (tx_cnt_q == 16'd0 && tx_bits_q == 4'd0));

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_line_d  = tx_line_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    if (tx_load) begin
      tx_busy_d = 1'b1;
      tx_line_d = 1'b0;
      tx_div_d  = div_q;
      tx_cnt_d  = div_q - 16'd1;
      if (ctrl_q[CTRL_PAR_EN]) begin
        tx_shift_d = {1'b1, parity_bit(tx_head, ctrl_q[CTRL_PAR_ODD]), tx_head};
        tx_bits_d  = 4'd10;
      end else begin
        tx_shift_d = {2'b11, tx_head};
        tx_bits_d  = 4'd9;
      end
    end else if (tx_busy_q) begin
      if (tx_cnt_q != 16'd0) begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end else if (tx_bits_q != 4'd0) begin
        tx_line_d  = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 4'd1;
        tx_cnt_d   = tx_div_q - 16'd1;
      end else begin
        tx_busy_d = 1'b0;
        tx_line_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_shift_q <= 10'h3FF;
      tx_bits_q  <= 4'd0;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= RESET_DIV;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_line_q  <= tx_line_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
    end
  end

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_div_d       = rx_div_q;
    rx_par_en_d    = rx_par_en_q;
    rx_par_odd_d   = rx_par_odd_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_par_d       = rx_par_q;
    rx_push        = 1'b0;
    frame_err_set  = 1'b0;
    parity_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d   = RX_START;
          rx_div_d     = div_q;
          rx_par_en_d  = ctrl_q[CTRL_PAR_EN];
          rx_par_odd_d = ctrl_q[CTRL_PAR_ODD];
          rx_cnt_d     = {1'b0, div_q[15:1]} - 16'd1;
        end
      end
      RX_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_sync2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_par_d   = rx_sync2_q;
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (!rx_sync2_q) begin
          frame_err_set = 1'b1;
          rx_state_d    = RX_WAIT_HIGH;
        end else if (rx_par_en_q && (rx_par_q != parity_bit(rx_shift_q, rx_par_odd_q))) begin
          parity_err_set = 1'b1;
          rx_state_d     = RX_IDLE;
        end else begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= 16'd0;
      rx_div_q     <= RESET_DIV;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_par_q     <= 1'b0;
    end else begin
      rx_sync1_q   <= uart_rx;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
    end
  end

endmodule

// File: tb/tb_rvsteel_uart_fifo.sv
// Directed bench for rvsteel_uart_fifo at divisor 10 (1 MHz clock, 100 kbaud).
module tb_rvsteel_uart_fifo;

  localparam logic [4:0] A_WDATA   = 5'h00;
  localparam logic [4:0] A_RDATA   = 5'h04;
  localparam logic [4:0] A_STATUS  = 5'h08;
  localparam logic [4:0] A_CTRL    = 5'h0C;
  localparam logic [4:0] A_DIVISOR = 5'h10;
  localparam logic [4:0] A_UNUSED  = 5'h14;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rw_address = 5'h0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = 32'h0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        uart_irq;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;
  logic [31:0] popped;
  logic        irq_mid;
  logic [8:0]  tx_bits;
  logic [7:0]  t4_bytes [9] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h77};

  rvsteel_uart_fifo #(
    .CLOCK_FREQUENCY (1000000),
    .UART_BAUD_RATE  (100000),
    .FIFO_DEPTH      (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_request  (write_request),
    .write_response (write_response),
    .uart_rx        (uart_rx),
    .uart_tx        (uart_tx),
    .uart_irq       (uart_irq)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    rw_address    = a;
    write_data    = d;
    write_request = 1'b1;
    tick;
    write_request = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    rw_address   = a;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    d = read_data;
  endtask

  // Drives one frame; stop bit begins at edge s, the DUT samples it at s+8.
  // pop_mid issues an RDATA read so its pop lands on that same edge.
  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                            input logic stop_bit, input logic pop_mid,
                            output logic [31:0] pop_val, output logic irq_s);
    pop_val = 32'hDEADBEEF;
    irq_s   = 1'bx;
    uart_rx = 1'b0;
    repeat (10) tick;
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (10) tick;
    end
    if (use_par) begin
      uart_rx = par_bit;
      repeat (10) tick;
    end
    uart_rx = stop_bit;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) begin
        irq_s = uart_irq;
        if (pop_mid) begin
          rw_address   = A_RDATA;
          read_request = 1'b1;
        end
      end
      if (i == 8 && pop_mid) begin
        read_request = 1'b0;
        pop_val      = read_data;
      end
      tick;
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    int waited;
    int lowc;

    // Reset state
    repeat (3) tick;
    check("rst_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_rdata", read_data, 32'h0);
    check("rst_resp", {30'h0, read_response, write_response}, 32'h0);
    check("rst_irq", {31'h0, uart_irq}, 32'h0);
    reset_n = 1'b1;
    tick;
    bus_read(A_STATUS, rd);   check("rst_status", rd, 32'h01);
    check("rd_response", {31'h0, read_response}, 32'h1);
    tick;
    check("rdata_idle_zero", read_data, 32'h0);
    bus_read(A_CTRL, rd);     check("rst_ctrl", rd, 32'h4);
    bus_read(A_DIVISOR, rd);  check("rst_div", rd, 32'd10);
    bus_write(A_DIVISOR, 32'd2);
    check("wr_response", {31'h0, write_response}, 32'h1);
    bus_read(A_DIVISOR, rd);  check("div_clamp", rd, 32'd4);
    bus_write(A_DIVISOR, 32'd10);
    bus_read(A_DIVISOR, rd);  check("div_restore", rd, 32'd10);
    bus_write(A_UNUSED, 32'hFFFF_FFFF);
    bus_read(A_UNUSED, rd);   check("unmapped_zero", rd, 32'h0);

    // 1: transmit 0x55
    bus_write(A_WDATA, 32'h55);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 20) begin tick; waited++; end
    check("t1_start_seen", {31'h0, uart_tx}, 32'h0);
    lowc = 0;
    while (uart_tx === 1'b0 && lowc < 40) begin tick; lowc++; end
    check("t1_start_len", lowc, 10);
    for (int i = 0; i < 9; i++) begin
      if (i == 0) repeat (4) tick;
      else repeat (10) tick;
      tx_bits[i] = uart_tx;
    end
    check("t1_data", {24'h0, tx_bits[7:0]}, 32'h55);
    check("t1_stop", {31'h0, tx_bits[8]}, 32'h1);
    waited = 0;
    rd = 32'h0;
    while (rd[0] !== 1'b1 && waited < 40) begin bus_read(A_STATUS, rd); waited++; end
    check("t1_tx_idle", rd, 32'h01);

    // 2: receive 0xA3 with rx_irq_en
    send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, popped, irq_mid);
    check("t2_irq_before", {31'h0, irq_mid}, 32'h0);
    check("t2_irq_after", {31'h0, uart_irq}, 32'h1);
    bus_read(A_STATUS, rd);  check("t2_status", rd, 32'h05);
    bus_read(A_RDATA, rd);   check("t2_rdata", rd, 32'hA3);
    tick;
    check("t2_irq_fall", {31'h0, uart_irq}, 32'h0);
    bus_read(A_RDATA, rd);   check("t2_rdata_empty", rd, 32'h0);

    // 3: TX overflow
    bus_write(A_WDATA, 32'h11);
    repeat (3) tick;
    for (int i = 0; i < 8; i++) bus_write(A_WDATA, 32'h20 + i);
    bus_read(A_STATUS, rd);  check("t3_full", rd, 32'h02);
    bus_write(A_WDATA, 32'h99);
    bus_read(A_STATUS, rd);  check("t3_ovf", rd, 32'h82);
    bus_write(A_STATUS, 32'h80);
    bus_read(A_STATUS, rd);  check("t3_ovf_clr", rd, 32'h02);
    waited = 0;
    rd = 32'h0;
    while (rd[0] !== 1'b1 && waited < 1500) begin bus_read(A_STATUS, rd); waited++; end
    check("t3_drained", rd, 32'h01);

    // 4: RX overrun and same-cycle pop+push while full
    for (int i = 0; i < 9; i++) begin
      send_frame(t4_bytes[i], 1'b0, 1'b0, 1'b1, 1'b0, popped, irq_mid);
      if (i < 8) exp_q.push_back(t4_bytes[i]);
      tick;
    end
    bus_read(A_STATUS, rd);  check("t4_overrun", rd, 32'h1D);
    bus_write(A_STATUS, 32'h10);
    bus_read(A_STATUS, rd);  check("t4_ovr_clr", rd, 32'h0D);
    send_frame(8'hE7, 1'b0, 1'b0, 1'b1, 1'b1, popped, irq_mid);
    check("t4_pop_push", popped, {24'h0, exp_q.pop_front()});
    exp_q.push_back(8'hE7);
    bus_read(A_STATUS, rd);  check("t4_no_ovr", rd, 32'h0D);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_RDATA, rd);
      check($sformatf("t4_order%0d", i), rd, {24'h0, exp_q.pop_front()});
    end
    bus_read(A_STATUS, rd);  check("t4_empty", rd, 32'h01);

    // 5: odd parity error, then framing error
    bus_write(A_CTRL, 32'h3);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, popped, irq_mid);
    tick;
    bus_read(A_STATUS, rd);  check("t5_parity_err", rd, 32'h41);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, popped, irq_mid);
    repeat (3) tick;
    bus_read(A_STATUS, rd);  check("t5_frame_err", rd, 32'h61);
    check("t5_irq_masked", {31'h0, uart_irq}, 32'h0);
    bus_write(A_STATUS, 32'hF0);
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STATUS, rd);  check("t5_clr", rd, 32'h01);

    // 6: short glitch, then reset during a TX frame
    uart_rx = 1'b0;
    repeat (3) tick;
    uart_rx = 1'b1;
    repeat (40) tick;
    bus_read(A_STATUS, rd);  check("t6_glitch", rd, 32'h01);
    bus_write(A_WDATA, 32'h5A);
    repeat (15) tick;
    check("t6_tx_mid", {31'h0, uart_tx}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("t6_tx_reset", {31'h0, uart_tx}, 32'h1);
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    bus_read(A_STATUS, rd);  check("t6_status", rd, 32'h01);
    bus_read(A_CTRL, rd);    check("t6_ctrl", rd, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
